// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states,
// combination count, stimulus width and the packed-table bit-index helper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_COMBOS = 8;
    localparam int unsigned IN_WIDTH   = 3;

    // Position of f_in[k] captured at combination i inside the packed table.
    function automatic int unsigned tbl_bit(input int unsigned k,
                                            input logic [IN_WIDTH-1:0] i);
        return k * NUM_COMBOS + 32'(i);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that holds each stimulus combination for
// SETTLE_CYCLES extra cycles; zero_o marks the cycle that ends the window.
module truth_table_sweeper_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic zero_o
);

    localparam int unsigned CNT_W =
        ($clog2(SETTLE_CYCLES + 1) > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives {a,b,c} through all eight combinations, samples f_in at the end of
// each settle window and presents the packed truth table with a done pulse.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned N_OUT         = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        a,
    output logic                        b,
    output logic                        c,
    input  logic [N_OUT-1:0]            f_in,
    output logic                        busy,
    output logic                        done,
    output logic                        valid,
    output logic [NUM_COMBOS*N_OUT-1:0] table_out,
    output state_t                      dbg_state_o
);

    localparam int unsigned TBL_W = NUM_COMBOS * N_OUT;

    state_t                state_q;
    logic [IN_WIDTH-1:0]   idx_q;
    logic [IN_WIDTH-1:0]   abc_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic [TBL_W-1:0]      table_q;
    logic [TBL_W-1:0]      table_d;
    logic [NUM_COMBOS-1:0] row;
    logic                  timer_load;
    logic                  timer_zero;

    // Reload on an accepted start and whenever we step to the next combination.
    assign timer_load = ((state_q == IDLE) && start) ||
                        ((state_q == HOLD) && timer_zero && (idx_q != 3'd7));

    truth_table_sweeper_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load),
        .zero_o (timer_zero)
    );

    always_comb begin
        table_d = table_q;
        row     = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            row        = table_q[tbl_bit(k, '0) +: NUM_COMBOS];
            row[idx_q] = f_in[k];
            table_d[tbl_bit(k, '0) +: NUM_COMBOS] = row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            table_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= HOLD;
                        idx_q   <= '0;
                        abc_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        table_q <= '0;
                    end
                end
                HOLD: begin
                    if (timer_zero) begin
                        table_q <= table_d;
                        if (idx_q == 3'd7) begin
                            state_q <= DONE;
                            abc_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            abc_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c}   = abc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign valid       = valid_q;
    assign table_out   = table_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (settle 1, 0, 3) driven by
// scenario tasks and checked against a table/timing model built from the rules.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [3];
    logic [1:0]  fin_v   [3];
    logic        a_w     [3];
    logic        b_w     [3];
    logic        c_w     [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        valid_w [3];
    logic [15:0] tbl_w   [3];
    logic [1:0]  dbg_w   [3];
    logic [15:0] rnd_word;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(1), .N_OUT(2)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .f_in(fin_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .valid(valid_w[0]),
        .table_out(tbl_w[0]), .dbg_state_o(dbg_w[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0), .N_OUT(2)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .f_in(fin_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .valid(valid_w[1]),
        .table_out(tbl_w[1]), .dbg_state_o(dbg_w[1])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3), .N_OUT(2)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .f_in(fin_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .valid(valid_w[2]),
        .table_out(tbl_w[2]), .dbg_state_o(dbg_w[2])
    );

    function automatic int s_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] abc_of(input int sel);
        return {a_w[sel], b_w[sel], c_w[sel]};
    endfunction

    // Function under test: 0 = scenario-2 pair, 1 = {c,a}, 2 = parity, 3 = random table.
    function automatic logic ref_bit(input int mode, input int i, input int k);
        logic ia, ib, ic;
        ia = 1'((i >> 2) & 1);
        ib = 1'((i >> 1) & 1);
        ic = 1'(i & 1);
        case (mode)
            0:       return (k == 0) ? (((ia & ib) | ~ic) ^ (~ib | ic))
                                     : (((ia | ib | ic) & (ia ^ ic)) | ~ib);
            1:       return (k == 0) ? ia : ic;
            2:       return ia ^ ib ^ ic;
            default: return rnd_word[8 * k + i];
        endcase
    endfunction

    task automatic run_sweep(input int sel, input int mode, input bit poke, input bit check_clear);
        int          s;
        int          len;
        int          idx;
        logic [15:0] exp_tbl;
        s   = s_of(sel);
        len = 8 * (s + 1);
        exp_tbl = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                exp_tbl[8 * k + i] = ref_bit(mode, i, k);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        for (int n = 1; n <= len; n++) begin
            idx = (n - 1) / (s + 1);
            n_tests++;
            if (abc_of(sel) !== 3'(idx)) begin
                n_fail++;
                $display("FAIL abc inst%0d cycle %0d: got %0d expected %0d", sel, n, abc_of(sel), idx);
            end
            n_tests++;
            if (busy_w[sel] !== 1'b1 || done_w[sel] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy/done inst%0d cycle %0d: got busy=%b done=%b expected busy=1 done=0",
                         sel, n, busy_w[sel], done_w[sel]);
            end
            if (n == 1 && check_clear) begin
                n_tests++;
                if (valid_w[sel] !== 1'b0 || tbl_w[sel] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL clear_on_start inst%0d: got valid=%b table=%h expected valid=0 table=0000",
                             sel, valid_w[sel], tbl_w[sel]);
                end
            end
            if (n % (s + 1) == 0)
                fin_v[sel] = {ref_bit(mode, idx, 1), ref_bit(mode, idx, 0)};
            else
                fin_v[sel] = 2'($urandom_range(0, 3));
            start_v[sel] = poke && (n == 3 || n == 10);
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        n_tests++;
        if (done_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || valid_w[sel] !== 1'b1 || abc_of(sel) !== 3'd0) begin
            n_fail++;
            $display("FAIL done_cycle inst%0d cycle %0d: got done=%b busy=%b valid=%b abc=%0d expected 1 0 1 0",
                     sel, len + 1, done_w[sel], busy_w[sel], valid_w[sel], abc_of(sel));
        end
        n_tests++;
        if (tbl_w[sel] !== exp_tbl) begin
            n_fail++;
            $display("FAIL table inst%0d mode %0d: got %h expected %h", sel, mode, tbl_w[sel], exp_tbl);
        end
        @(negedge clk);
        n_tests++;
        if (done_w[sel] !== 1'b0 || valid_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || tbl_w[sel] !== exp_tbl) begin
            n_fail++;
            $display("FAIL after_done inst%0d: got done=%b valid=%b busy=%b table=%h expected 0 1 0 %h",
                     sel, done_w[sel], valid_w[sel], busy_w[sel], tbl_w[sel], exp_tbl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int j = 0; j < 3; j++) begin
            start_v[j] = 1'b1;
            fin_v[j]   = 2'b11;
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if ({abc_of(j), busy_w[j], done_w[j], valid_w[j], tbl_w[j]} !== 22'h0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: got abc=%0d busy=%b done=%b valid=%b table=%h expected all 0",
                         j, abc_of(j), busy_w[j], done_w[j], valid_w[j], tbl_w[j]);
            end
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) start_v[j] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                n_tests++;
                if (busy_w[j] !== 1'b0 || abc_of(j) !== 3'd0 || done_w[j] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_after_reset inst%0d: got busy=%b abc=%0d done=%b expected 0 0 0",
                             j, busy_w[j], abc_of(j), done_w[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int n = 1; n < 7; n++) begin
            fin_v[0] = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        n_tests++;
        if (abc_of(0) !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_abc: got %0d expected 3", abc_of(0));
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if ({abc_of(0), busy_w[0], done_w[0], valid_w[0], tbl_w[0]} !== 22'h0) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: got abc=%0d busy=%b done=%b valid=%b table=%h expected all 0",
                     abc_of(0), busy_w[0], done_w[0], valid_w[0], tbl_w[0]);
        end
        repeat (20) begin
            @(negedge clk);
            n_tests++;
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL no_done_after_reset: got done=%b busy=%b expected 0 0", done_w[0], busy_w[0]);
            end
        end
        rnd_word = 16'($urandom);
        run_sweep(0, 3, 1'b0, 1'b1);
    endtask

    task automatic test_start_held();
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            fin_v[1] = 2'($urandom_range(0, 3));
            if (n == 9) begin
                n_tests++;
                if (done_w[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL held_done: got %b expected 1", done_w[1]);
                end
            end
            if (n == 10) begin
                n_tests++;
                if (busy_w[1] !== 1'b0 || valid_w[1] !== 1'b1 || done_w[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_idle_gap: got busy=%b valid=%b done=%b expected 0 1 0",
                             busy_w[1], valid_w[1], done_w[1]);
                end
            end
            if (n == 11) begin
                n_tests++;
                if (busy_w[1] !== 1'b1 || valid_w[1] !== 1'b0 || abc_of(1) !== 3'd0) begin
                    n_fail++;
                    $display("FAIL held_restart: got busy=%b valid=%b abc=%0d expected 1 0 0",
                             busy_w[1], valid_w[1], abc_of(1));
                end
            end
        end
        start_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (busy_w[1] !== 1'b0 || valid_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL held_finish: got busy=%b valid=%b expected 0 1", busy_w[1], valid_w[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rnd_word = '0;
        test_reset();
        run_sweep(0, 0, 1'b0, 1'b1);          // settle 1, scenario-2 functions
        run_sweep(1, 1, 1'b0, 1'b1);          // settle 0, f0=a f1=c
        run_sweep(0, 0, 1'b1, 1'b1);          // stray starts mid-sweep
        run_sweep(0, 0, 1'b0, 1'b1);          // restart after valid result
        test_reset_mid_sweep();
        run_sweep(2, 2, 1'b0, 1'b1);          // settle 3, parity with noise
        for (int r = 0; r < 6; r++) begin
            rnd_word = 16'($urandom);
            run_sweep(r % 3, 3, r[0], 1'b1);
        end
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus and capture stage for the team's combinational NAND-built logic functions. On request it drives {a,b,c} through all 8 combinations in ascending order. For each combination it waits a programmable settle time, then samples the function outputs. It assembles the results into a packed truth table with a done handshake, replacing hand-written per-combination testbench stimulus.

Parameters:
SETTLE_CYCLES, 1, extra cycles each combination is held before sampling; 0 is legal.
N_OUT, 2, number of 1-bit function outputs sampled in parallel.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
start  in  1  sweep request, sampled only in IDLE
a  out  1  stimulus MSB (combination index bit 2)
b  out  1  stimulus bit 1
c  out  1  stimulus LSB (combination index bit 0)
f_in  in  N_OUT  function outputs from the downstream combinational block
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when the table is complete
valid  out  1  table_out holds a complete sweep; level signal
table_out  out  8*N_OUT  table_out[8*k+i] = f_in[k] sampled at combination i = {a,b,c}

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; a=b=c=0, busy=0, done=0, valid=0, table_out=0, index=0, settle counter=0. Reset wins over every other event, including mid-sweep; the sweep is abandoned with no partial result.
- States:
  - IDLE: start=1 -> HOLD, index=0, {a,b,c}=000, busy=1, valid=0, table_out cleared, counter=SETTLE_CYCLES.
  - HOLD: if counter!=0, decrement. If counter==0, sample f_in into bits 8*k+index, then:
    - index==7 -> DONE.
    - else index+1, {a,b,c}=index+1, counter reloaded, stay in HOLD.
  - DONE: done=1, busy=0, valid=1 for exactly this cycle; next state IDLE. {a,b,c} return to 000.
- Timing:
  - Each combination is stable on a,b,c for exactly SETTLE_CYCLES+1 cycles.
  - f_in is sampled only at the rising edge that ends that window; f_in is don't-care in all other cycles.
  - Let E0 be the edge that samples start. Combination i is visible in cycles i*(S+1)+1 .. (i+1)*(S+1).
  - done is high in cycle 8*(S+1)+1 (S=1 -> cycle 17; S=0 -> cycle 9).
- start while busy or in DONE: ignored, no restart, no error.
- start held high continuously: a new sweep begins from the IDLE cycle after DONE.
- valid: stays high and table_out stays frozen until the next accepted start, which clears both on the same edge.
- Counter width: max(1, clog2(SETTLE_CYCLES+1)). Index is 3 bits and never wraps, because DONE is entered before overflow.
- a,b,c are registered outputs: no combinational path from start or f_in.

Decomposition:
- Shared package holds:
  - state enum {IDLE, HOLD, DONE}
  - NUM_COMBOS=8
  - IN_WIDTH=3
  - the table bit-index helper (k*8+i)
- One natural sub-module: settle_timer, a loadable down-counter with load/zero ports parameterised by SETTLE_CYCLES.
- The FSM, index register and table register stay in truth_table_sweeper.

Test Plan:
1. Hold rst_n=0 for 2 cycles with start=1 -> all outputs 0, no sweep starts; release with start=0 -> stays IDLE, a=b=c=0.
2. SETTLE_CYCLES=1, N_OUT=2, f_in[0]=((a&b)|~c)^(~b|c), f_in[1]=((a|b|c)&(a^c))|~b, pulse start -> table_out=16'h7B6E; done pulses in cycle 17 only; valid=1 afterwards; each abc value held 2 cycles.
3. SETTLE_CYCLES=0, f_in[0]=a, f_in[1]=c -> table_out=16'hAAF0; done in cycle 9; abc steps every cycle 000..111.
4. Pulse start again in cycles 3 and 10 of a sweep -> ignored, result and done timing identical to scenario 2. Then start after done -> valid drops on the accepting edge and a fresh sweep produces the same table.
5. Drive rst_n=0 while abc=011 -> next cycle all outputs 0, valid=0, no done pulse. A subsequent start begins again at 000.
6. SETTLE_CYCLES=3 with f_in toggled randomly in non-sampling cycles and equal to the index parity at sampling edges -> table_out[7:0]=8'h96; only sampling-edge values captured.
